// File: rtl/control_unit_if.sv
// Control bundle between the Mini SRC control unit and its datapath.
// master = control unit, slave = datapath side.
interface control_unit_if;
    logic        Stop;
    logic        CON_FF;
    logic [31:0] IR;
    logic [1:0]  interrupt;

    logic Run, ClearSig, Read, Write;
    logic ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, DIV, MUL, NEG, NOT;
    logic PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OutPortIn, RAin, Rin;
    logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, OutPortOut, Rout, BAout;
    logic Gra, Grb, Grc, IncPC;

    modport master (
        input  Stop, CON_FF, IR, interrupt,
        output Run, ClearSig, Read, Write,
        output ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, DIV, MUL, NEG, NOT,
        output PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OutPortIn, RAin, Rin,
        output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, OutPortOut, Rout, BAout,
        output Gra, Grb, Grc, IncPC
    );

    modport slave (
        output Stop, CON_FF, IR, interrupt,
        input  Run, ClearSig, Read, Write,
        input  ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, DIV, MUL, NEG, NOT,
        input  PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OutPortIn, RAin, Rin,
        input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, OutPortOut, Rout, BAout,
        input  Gra, Grb, Grc, IncPC
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control unit for Mini SRC: 3-step fetch, then opcode-specific T3..T7.
// Strobes are decoded from the current state and IR opcode (br T6 also looks at CON_FF).
module control_unit (
    input  logic           Clock,
    input  logic           Reset,
    control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [4:0] {
        OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_ROR  = 5'd7,
        OP_ROL  = 5'd8,  OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11,
        OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_DIV  = 5'd15,
        OP_MUL  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19,
        OP_JAL  = 5'd20, OP_JR   = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23,
        OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27
    } op_e;

    localparam int unsigned ALU_W    = 13;
    localparam int unsigned ALU_ADD  = 12;
    localparam int unsigned ALU_SUB  = 11;
    localparam int unsigned ALU_AND  = 10;
    localparam int unsigned ALU_OR   = 9;
    localparam int unsigned ALU_ROR  = 8;
    localparam int unsigned ALU_ROL  = 7;
    localparam int unsigned ALU_SHR  = 6;
    localparam int unsigned ALU_SHRA = 5;
    localparam int unsigned ALU_SHL  = 4;
    localparam int unsigned ALU_DIV  = 3;
    localparam int unsigned ALU_MUL  = 2;
    localparam int unsigned ALU_NEG  = 1;
    localparam int unsigned ALU_NOT  = 0;

    state_e             state_q, state_d, done_state;
    op_e                opcode;
    logic [ALU_W-1:0]   op_alu, alu_sel;
    logic               is_rtype, is_imm, is_muldiv, is_unary, is_mem, is_nop;
    logic               t3_last, t4_last, t5_last, t6_last;
    logic               unused_ok;

    assign opcode    = op_e'(bus.IR[31:27]);
    assign unused_ok = ^{bus.IR[26:0], bus.interrupt};

    // Instruction classes and the step at which each instruction finishes
    assign is_rtype  = (opcode >= OP_ADD)  && (opcode <= OP_SHL);
    assign is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_muldiv = (opcode == OP_MUL)  || (opcode == OP_DIV);
    assign is_unary  = (opcode == OP_NEG)  || (opcode == OP_NOT);
    assign is_mem    = (opcode <= OP_ST);
    assign is_nop    = (opcode == OP_NOP)  || (5'(opcode) > 5'd27);
    assign t3_last   = (opcode >= OP_JR)   && (opcode <= OP_MFLO);
    assign t4_last   = is_unary || (opcode == OP_JAL);
    assign t5_last   = is_rtype || is_imm || (opcode == OP_LDI);
    assign t6_last   = is_muldiv || (opcode == OP_BR);
    assign done_state = bus.Stop ? S_HALT : S_T0;

    // ALU operation implied by the opcode, used only in the compute step
    always_comb begin
        op_alu = '0;
        case (opcode)
            OP_ADD, OP_ADDI: op_alu[ALU_ADD]  = 1'b1;
            OP_SUB:          op_alu[ALU_SUB]  = 1'b1;
            OP_AND, OP_ANDI: op_alu[ALU_AND]  = 1'b1;
            OP_OR,  OP_ORI:  op_alu[ALU_OR]   = 1'b1;
            OP_ROR:          op_alu[ALU_ROR]  = 1'b1;
            OP_ROL:          op_alu[ALU_ROL]  = 1'b1;
            OP_SHR:          op_alu[ALU_SHR]  = 1'b1;
            OP_SHRA:         op_alu[ALU_SHRA] = 1'b1;
            OP_SHL:          op_alu[ALU_SHL]  = 1'b1;
            OP_DIV:          op_alu[ALU_DIV]  = 1'b1;
            OP_MUL:          op_alu[ALU_MUL]  = 1'b1;
            OP_NEG:          op_alu[ALU_NEG]  = 1'b1;
            OP_NOT:          op_alu[ALU_NOT]  = 1'b1;
            default:         op_alu = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        alu_sel        = '0;
        bus.Read       = 1'b0; bus.Write      = 1'b0;
        bus.PCin       = 1'b0; bus.IRin       = 1'b0; bus.Yin        = 1'b0;
        bus.Zin        = 1'b0; bus.MARin      = 1'b0; bus.MDRin      = 1'b0;
        bus.HIin       = 1'b0; bus.LOin       = 1'b0; bus.CONin      = 1'b0;
        bus.OutPortIn  = 1'b0; bus.RAin       = 1'b0; bus.Rin        = 1'b0;
        bus.PCout      = 1'b0; bus.MDRout     = 1'b0; bus.Zhighout   = 1'b0;
        bus.Zlowout    = 1'b0; bus.HIout      = 1'b0; bus.LOout      = 1'b0;
        bus.Cout       = 1'b0; bus.OutPortOut = 1'b0; bus.Rout       = 1'b0;
        bus.BAout      = 1'b0; bus.Gra        = 1'b0; bus.Grb        = 1'b0;
        bus.Grc        = 1'b0; bus.IncPC      = 1'b0;

        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                if (opcode == OP_HALT) state_d = S_HALT;
                else if (is_nop)       state_d = done_state;
                else                   state_d = S_T3;
            end
            S_T3: begin
                state_d = t3_last ? done_state : S_T4;
                if (is_rtype || is_imm) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                end else if (is_unary) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; alu_sel = op_alu;
                end else if (is_muldiv) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                end else if (is_mem) begin
                    bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                end else begin
                    case (opcode)
                        OP_BR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                        OP_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                        OP_JAL:  begin bus.PCout = 1'b1; bus.RAin = 1'b1; end
                        OP_IN:   begin bus.OutPortOut = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                        OP_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortIn = 1'b1; end
                        OP_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                        OP_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                state_d = t4_last ? done_state : S_T5;
                if (is_rtype) begin
                    bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; alu_sel = op_alu;
                end else if (is_imm) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1; alu_sel = op_alu;
                end else if (is_unary) begin
                    bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (is_muldiv) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; alu_sel = op_alu;
                end else if (is_mem) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1; alu_sel[ALU_ADD] = 1'b1;
                end else if (opcode == OP_BR) begin
                    bus.PCout = 1'b1; bus.Yin = 1'b1;
                end else if (opcode == OP_JAL) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
                end
            end
            S_T5: begin
                state_d = t5_last ? done_state : S_T6;
                if (t5_last) begin
                    bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (is_muldiv) begin
                    bus.Zlowout = 1'b1; bus.LOin = 1'b1;
                end else if (is_mem) begin
                    bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                end else if (opcode == OP_BR) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1; alu_sel[ALU_ADD] = 1'b1;
                end
            end
            S_T6: begin
                state_d = t6_last ? done_state : S_T7;
                if (is_muldiv) begin
                    bus.Zhighout = 1'b1; bus.HIin = 1'b1;
                end else if (opcode == OP_LD) begin
                    bus.Read = 1'b1; bus.MDRin = 1'b1;
                end else if (opcode == OP_ST) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                end else if (opcode == OP_BR) begin
                    bus.Zlowout = 1'b1; bus.PCin = bus.CON_FF;
                end
            end
            S_T7: begin
                state_d = done_state;
                if (opcode == OP_LD) begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (opcode == OP_ST) begin
                    bus.Write = 1'b1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    assign {bus.ADD, bus.SUB, bus.AND, bus.OR, bus.ROR, bus.ROL, bus.SHR,
            bus.SHRA, bus.SHL, bus.DIV, bus.MUL, bus.NEG, bus.NOT} = alu_sel;
    assign bus.Run      = (state_q != S_RESET) && (state_q != S_HALT);
    assign bus.ClearSig = (state_q == S_RESET);
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected strobe vectors are queued by the
// stimulus and compared against the DUT by an independent negedge monitor.
module tb_control_unit;
    logic Clock = 1'b0;
    logic Reset;
    control_unit_if cu_if ();

    control_unit dut (.Clock(Clock), .Reset(Reset), .bus(cu_if));

    always #5 Clock = ~Clock;

    localparam logic [42:0] M_RUN   = 43'(1) << 42, M_CLR    = 43'(1) << 41;
    localparam logic [42:0] M_READ  = 43'(1) << 40, M_WRITE  = 43'(1) << 39;
    localparam logic [42:0] M_ADD   = 43'(1) << 38, M_SUB    = 43'(1) << 37;
    localparam logic [42:0] M_AND   = 43'(1) << 36, M_OR     = 43'(1) << 35;
    localparam logic [42:0] M_ROR   = 43'(1) << 34, M_ROL    = 43'(1) << 33;
    localparam logic [42:0] M_SHR   = 43'(1) << 32, M_SHRA   = 43'(1) << 31;
    localparam logic [42:0] M_SHL   = 43'(1) << 30, M_DIV    = 43'(1) << 29;
    localparam logic [42:0] M_MUL   = 43'(1) << 28, M_NEG    = 43'(1) << 27;
    localparam logic [42:0] M_NOT   = 43'(1) << 26, M_PCIN   = 43'(1) << 25;
    localparam logic [42:0] M_IRIN  = 43'(1) << 24, M_YIN    = 43'(1) << 23;
    localparam logic [42:0] M_ZIN   = 43'(1) << 22, M_MARIN  = 43'(1) << 21;
    localparam logic [42:0] M_MDRIN = 43'(1) << 20, M_HIIN   = 43'(1) << 19;
    localparam logic [42:0] M_LOIN  = 43'(1) << 18, M_CONIN  = 43'(1) << 17;
    localparam logic [42:0] M_OPIN  = 43'(1) << 16, M_RAIN   = 43'(1) << 15;
    localparam logic [42:0] M_RIN   = 43'(1) << 14, M_PCOUT  = 43'(1) << 13;
    localparam logic [42:0] M_MDROUT= 43'(1) << 12, M_ZHI    = 43'(1) << 11;
    localparam logic [42:0] M_ZLO   = 43'(1) << 10, M_HIOUT  = 43'(1) << 9;
    localparam logic [42:0] M_LOOUT = 43'(1) << 8,  M_COUT   = 43'(1) << 7;
    localparam logic [42:0] M_OPOUT = 43'(1) << 6,  M_ROUT   = 43'(1) << 5;
    localparam logic [42:0] M_BAOUT = 43'(1) << 4,  M_GRA    = 43'(1) << 3;
    localparam logic [42:0] M_GRB   = 43'(1) << 2,  M_GRC    = 43'(1) << 1;
    localparam logic [42:0] M_INCPC = 43'(1);

    localparam logic [42:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [42:0] F1 = M_RUN | M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [42:0] F2 = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [42:0] WB = M_RUN | M_ZLO | M_GRA | M_RIN;

    logic [42:0] act;
    assign act = {cu_if.Run, cu_if.ClearSig, cu_if.Read, cu_if.Write,
                  cu_if.ADD, cu_if.SUB, cu_if.AND, cu_if.OR, cu_if.ROR, cu_if.ROL, cu_if.SHR,
                  cu_if.SHRA, cu_if.SHL, cu_if.DIV, cu_if.MUL, cu_if.NEG, cu_if.NOT,
                  cu_if.PCin, cu_if.IRin, cu_if.Yin, cu_if.Zin, cu_if.MARin, cu_if.MDRin,
                  cu_if.HIin, cu_if.LOin, cu_if.CONin, cu_if.OutPortIn, cu_if.RAin, cu_if.Rin,
                  cu_if.PCout, cu_if.MDRout, cu_if.Zhighout, cu_if.Zlowout, cu_if.HIout,
                  cu_if.LOout, cu_if.Cout, cu_if.OutPortOut, cu_if.Rout, cu_if.BAout,
                  cu_if.Gra, cu_if.Grb, cu_if.Grc, cu_if.IncPC};

    logic [42:0] exp_q [$];
    string       name_q [$];
    int          checks = 0;
    int          errors = 0;

    // Monitor: one queued expectation per cycle, compared mid-cycle
    initial begin
        logic [42:0] e;
        string       n;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic cyc(input logic [42:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string p);
        cyc(F0, {p, " t0"});
        cyc(F1, {p, " t1"});
        cyc(F2, {p, " t2"});
    endtask

    // R-type then immediate opcodes (top byte of IR) with their ALU strobe
    logic [7:0]  rt_op  [12] = '{8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h40, 8'h48, 8'h50,
                                 8'h58, 8'h60, 8'h68, 8'h70};
    logic [42:0] rt_alu [12] = '{M_ADD, M_SUB, M_AND, M_OR, M_ROR, M_ROL, M_SHR, M_SHRA,
                                 M_SHL, M_ADD, M_AND, M_OR};

    initial begin
        Reset = 1'b1; cu_if.Stop = 1'b0; cu_if.CON_FF = 1'b0;
        cu_if.IR = 32'h0; cu_if.interrupt = 2'b00;
        @(posedge Clock); #1;
        cyc(M_CLR, "reset held 1");
        Reset = 1'b0;
        cyc(M_CLR, "reset held 2");

        cu_if.IR = 32'h61A7FFFB;
        fetch("addi");
        cyc(M_RUN | M_GRB | M_ROUT | M_YIN, "addi t3");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN, "addi t4");
        cyc(WB, "addi t5");

        for (int i = 0; i < 12; i++) begin
            cu_if.IR = {rt_op[i], 24'h912345};
            fetch("alu");
            cyc(M_RUN | M_GRB | M_ROUT | M_YIN, "alu t3");
            if (i < 9) cyc(M_RUN | M_GRC | M_ROUT | M_ZIN | rt_alu[i], "rtype t4");
            else       cyc(M_RUN | M_COUT | M_ZIN | rt_alu[i], "imm t4");
            cyc(WB, "alu t5");
        end

        cu_if.IR = 32'h00800005;
        fetch("ld");
        cyc(M_RUN | M_GRB | M_BAOUT | M_YIN, "ld t3");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN, "ld t4");
        cyc(M_RUN | M_ZLO | M_MARIN, "ld t5");
        cyc(M_RUN | M_READ | M_MDRIN, "ld t6");
        cyc(M_RUN | M_MDROUT | M_GRA | M_RIN, "ld t7");

        cu_if.IR = 32'h08800005;
        fetch("ldi");
        cyc(M_RUN | M_GRB | M_BAOUT | M_YIN, "ldi t3");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN, "ldi t4");
        cyc(WB, "ldi t5");

        cu_if.IR = 32'h10800005;
        fetch("st");
        cyc(M_RUN | M_GRB | M_BAOUT | M_YIN, "st t3");
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN, "st t4");
        cyc(M_RUN | M_ZLO | M_MARIN, "st t5");
        cyc(M_RUN | M_GRA | M_ROUT | M_MDRIN, "st t6");
        cyc(M_RUN | M_WRITE, "st t7");

        for (int c = 0; c < 2; c++) begin
            cu_if.IR = 32'h99000003;
            cu_if.CON_FF = (c == 1);
            fetch("br");
            cyc(M_RUN | M_GRA | M_ROUT | M_CONIN, "br t3");
            cyc(M_RUN | M_PCOUT | M_YIN, "br t4");
            cyc(M_RUN | M_COUT | M_ADD | M_ZIN, "br t5");
            cyc(M_RUN | M_ZLO | ((c == 1) ? M_PCIN : 43'(0)), "br t6");
        end
        cu_if.CON_FF = 1'b0;

        for (int m = 0; m < 2; m++) begin
            cu_if.IR = (m == 0) ? 32'h81100000 : 32'h79100000;
            fetch("muldiv");
            cyc(M_RUN | M_GRA | M_ROUT | M_YIN, "muldiv t3");
            cyc(M_RUN | M_GRB | M_ROUT | M_ZIN | ((m == 0) ? M_MUL : M_DIV), "muldiv t4");
            cyc(M_RUN | M_ZLO | M_LOIN, "muldiv t5");
            cyc(M_RUN | M_ZHI | M_HIIN, "muldiv t6");
        end

        for (int u = 0; u < 2; u++) begin
            cu_if.IR = (u == 0) ? 32'h88800000 : 32'h90800000;
            fetch("unary");
            cyc(M_RUN | M_GRB | M_ROUT | M_ZIN | ((u == 0) ? M_NEG : M_NOT), "unary t3");
            cyc(WB, "unary t4");
        end

        cu_if.IR = 32'hA0800000;
        fetch("jal");
        cyc(M_RUN | M_PCOUT | M_RAIN, "jal t3");
        cyc(M_RUN | M_GRA | M_ROUT | M_PCIN, "jal t4");

        cu_if.IR = 32'hA8800000; fetch("jr");
        cyc(M_RUN | M_GRA | M_ROUT | M_PCIN, "jr t3");
        cu_if.IR = 32'hB0800000; fetch("in");
        cyc(M_RUN | M_OPOUT | M_GRA | M_RIN, "in t3");
        cu_if.IR = 32'hB8800000; fetch("out");
        cyc(M_RUN | M_GRA | M_ROUT | M_OPIN, "out t3");
        cu_if.IR = 32'hC0800000; fetch("mfhi");
        cyc(M_RUN | M_HIOUT | M_GRA | M_RIN, "mfhi t3");
        cu_if.IR = 32'hC8800000; fetch("mflo");
        cyc(M_RUN | M_LOOUT | M_GRA | M_RIN, "mflo t3");

        cu_if.IR = 32'hD0000000; fetch("nop");
        cu_if.IR = 32'hF8000000; fetch("unused op");

        cu_if.IR = 32'h00800005;
        fetch("ld abort");
        cyc(M_RUN | M_GRB | M_BAOUT | M_YIN, "ld abort t3");
        Reset = 1'b1;
        cyc(M_RUN | M_COUT | M_ADD | M_ZIN, "ld abort t4");
        Reset = 1'b0;
        cyc(M_CLR, "reset mid ld");

        cu_if.IR = 32'h18000000;
        fetch("add stop");
        cyc(M_RUN | M_GRB | M_ROUT | M_YIN, "add stop t3");
        cyc(M_RUN | M_GRC | M_ROUT | M_ZIN | M_ADD, "add stop t4");
        cu_if.Stop = 1'b1;
        cyc(WB, "add stop t5");
        cu_if.Stop = 1'b0;
        cu_if.IR = 32'h00800005;
        for (int h = 0; h < 3; h++) cyc(43'(0), "halt after stop");
        Reset = 1'b1;
        cyc(43'(0), "halt before reset");
        Reset = 1'b0;
        cyc(M_CLR, "reset from stop halt");

        cu_if.IR = 32'hD8000000;
        fetch("halt op");
        cu_if.Stop = 1'b1;
        for (int h = 0; h < 3; h++) cyc(43'(0), "halt op idle");
        cu_if.Stop = 1'b0;
        Reset = 1'b1;
        cyc(43'(0), "halt op before reset");
        Reset = 1'b0;
        cu_if.IR = 32'hD0000000;
        cyc(M_CLR, "reset from halt op");
        fetch("final nop");
        cyc(F0, "final t0");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
